uart_rx_frame: RTL and testbench

//  Parametrised UART receiver: oversampled majority-vote bit recovery, configurable data/parity/stop

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_fifo.sv | 64 ++++++
 rtl/uart_rx_frame.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//  - PARITY_NONE / PARITY_ODD / PARITY_EVEN : codes for the PARITY parameter
//  - rx_state_e : receiver FSM states
//  - cnt_width(n) : bits needed to hold the values 0..n-1 (at least 1)
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO holding received words.
// Ports:
//  clk, resetn     clock, asynchronous active-low reset
//  push, wdata     write request and word; ignored when full unless popping
//  pop             read request; the head word is on rdata while !empty
//  rdata           head word (0 while empty)
//  full, empty     occupancy flags
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = cnt_width(DEPTH);
  localparam int CW = cnt_width(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: storage array has no reset; the counters alone define which entries are valid,
  // and the read side is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: 2-flop synchroniser, oversampled 3-sample majority vote,
// configurable data/parity/stop format, per-word error flags and a
// valid/ready output buffer.
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise
// a single holding register with identical ports, handshake and latency.
// Ports:
//  clk, resetn          clock, asynchronous active-low reset
//  uart_rxd             serial input (asynchronous to clk)
//  uart_rx_en           receive enable; low aborts a frame in progress
//  uart_rx_ready        consumer accepts the presented word this cycle
//  uart_rx_valid        word available
//  uart_rx_data         received data
//  uart_rx_parity_err   parity mismatch (always 0 when PARITY = none)
//  uart_rx_frame_err    first stop bit sampled 0
//  uart_rx_break        frame error with all-zero data
//  uart_rx_overrun      one-cycle pulse: completed word dropped, buffer full
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 9600,
  parameter int OVERSAMPLE   = 16,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  input  logic                    uart_rx_ready,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_parity_err,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break,
  output logic                    uart_rx_overrun
);

  localparam int TICK_DIV = CLK_HZ / BIT_RATE / OVERSAMPLE;
  localparam int TW       = cnt_width(TICK_DIV);
  localparam int SW       = cnt_width(OVERSAMPLE);
  localparam int BW       = cnt_width(PAYLOAD_BITS);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || TICK_DIV < 2 ||
      PAYLOAD_BITS < 5 || PAYLOAD_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_rx_frame: illegal parameter combination");
  end

  logic                    rxd_meta;
  logic                    rxd_s;
  rx_state_e               state;
  logic [TW-1:0]           tick_cnt;
  logic [SW-1:0]           samp_cnt;
  logic [BW-1:0]           bit_cnt;
  logic                    stop_cnt;
  logic                    v0;
  logic                    v1;
  logic [PAYLOAD_BITS-1:0] shift;
  logic                    par_err_q;
  logic                    frm_err_q;

  logic tick;
  logic mid_tick;
  logic vote;
  logic last_stop;
  logic commit;
  logic frame_err_now;
  logic word_break;
  logic pop;

  // Sample ticks only run while a frame is being tracked.
  assign tick          = (state != ST_IDLE) && (tick_cnt == TW'(TICK_DIV - 1));
  // Bit decisions are taken on the third voting tick.
  assign mid_tick      = tick && (samp_cnt == SW'(OVERSAMPLE / 2 + 1));
  assign vote          = (v0 & v1) | (v0 & rxd_s) | (v1 & rxd_s);
  assign last_stop     = (stop_cnt == 1'(STOP_BITS - 1));
  assign commit        = uart_rx_en && (state == ST_STOP) && mid_tick && last_stop;
  // Only the first stop bit contributes to the framing error.
  assign frame_err_now = (stop_cnt == 1'b0) ? ~vote : frm_err_q;
  assign word_break    = frame_err_now && (shift == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      v0        <= 1'b1;
      v1        <= 1'b1;
      shift     <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      // Counters sit at zero in IDLE, so they restart on every IDLE->START.
      if (state == ST_IDLE) begin
        tick_cnt <= '0;
        samp_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= '0;
        samp_cnt <= (samp_cnt == SW'(OVERSAMPLE - 1)) ? '0 : samp_cnt + SW'(1);
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end

      if (tick && samp_cnt == SW'(OVERSAMPLE / 2 - 1)) v0 <= rxd_s;
      if (tick && samp_cnt == SW'(OVERSAMPLE / 2))     v1 <= rxd_s;

      if (!uart_rx_en && state != ST_IDLE) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (uart_rx_en && !rxd_s) begin
              state     <= ST_START;
              par_err_q <= 1'b0;
            end
          end
          ST_START: begin
            if (mid_tick) begin
              state   <= vote ? ST_IDLE : ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            if (mid_tick) begin
              shift <= {vote, shift[PAYLOAD_BITS-1:1]};
              if (bit_cnt == BW'(PAYLOAD_BITS - 1)) begin
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                state    <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end
          ST_PARITY: begin
            if (mid_tick) begin
              // Even: any odd ones-count is an error; odd: the inverse.
              par_err_q <= (^shift) ^ vote ^ (PARITY == PARITY_ODD);
              stop_cnt  <= 1'b0;
              state     <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (mid_tick) begin
              if (stop_cnt == 1'b0) frm_err_q <= ~vote;
              if (last_stop) begin
                state <= frame_err_now ? ST_WAIT_HIGH : ST_IDLE;
              end else begin
                stop_cnt <= 1'b1;
              end
            end
          end
          ST_WAIT_HIGH: begin
            // Hold off until the line idles so a long break yields one word.
            if (rxd_s) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef UART_RX_FIFO_EN
  logic [PAYLOAD_BITS+2:0] fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;

  assign uart_rx_valid = ~fifo_empty;
  assign pop           = uart_rx_valid & uart_rx_ready;
  assign {uart_rx_break, uart_rx_frame_err, uart_rx_parity_err, uart_rx_data} = fifo_rdata;

  uart_rx_fifo #(
    .WIDTH (PAYLOAD_BITS + 3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (commit),
    .pop    (pop),
    .wdata  ({word_break, frame_err_now, par_err_q, shift}),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) uart_rx_overrun <= 1'b0;
    else         uart_rx_overrun <= commit & fifo_full & ~pop;
  end
`else
  assign pop = uart_rx_valid & uart_rx_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      uart_rx_valid      <= 1'b0;
      uart_rx_data       <= '0;
      uart_rx_parity_err <= 1'b0;
      uart_rx_frame_err  <= 1'b0;
      uart_rx_break      <= 1'b0;
      uart_rx_overrun    <= 1'b0;
    end else begin
      uart_rx_overrun <= commit & uart_rx_valid & ~pop;
      if (commit && (!uart_rx_valid || pop)) begin
        uart_rx_valid      <= 1'b1;
        uart_rx_data       <= shift;
        uart_rx_parity_err <= par_err_q;
        uart_rx_frame_err  <= frame_err_now;
        uart_rx_break      <= word_break;
      end else if (pop) begin
        uart_rx_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: an 8N1 instance and an 8E2 instance
// driven by directed and random frames. Expected words come from a frame-level
// model and are queued per instance; one compare process checks every cycle.
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam int CLK_HZ   = 50_000_000;
  localparam int BIT_RATE = 115200;
  localparam int OS       = 16;
  localparam int BIT_CYC  = (CLK_HZ / BIT_RATE / OS) * OS;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic rx_en  = 1'b1;
  logic ready  = 1'b1;
  logic rxd_n  = 1'b1;
  logic rxd_e  = 1'b1;
  logic rand_ready = 1'b0;

  logic       valid_n, pe_n, fe_n, brk_n, ov_n;
  logic [7:0] data_n;
  logic       valid_e, pe_e, fe_e, brk_e, ov_e;
  logic [7:0] data_e;

  int n_vec = 0;
  int n_err = 0;
  int vcnt_n = 0;
  int ov_cnt_n = 0;
  int ov_cnt_e = 0;
  logic [10:0] last_n = '0;
  logic [10:0] last_e = '0;
  logic [10:0] exp_n[$];
  logic [10:0] exp_e[$];

  uart_rx_frame #(
    .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .OVERSAMPLE(OS), .PAYLOAD_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_n (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_n), .uart_rx_en(rx_en),
    .uart_rx_ready(ready), .uart_rx_valid(valid_n), .uart_rx_data(data_n),
    .uart_rx_parity_err(pe_n), .uart_rx_frame_err(fe_n),
    .uart_rx_break(brk_n), .uart_rx_overrun(ov_n)
  );

  uart_rx_frame #(
    .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .OVERSAMPLE(OS), .PAYLOAD_BITS(8),
    .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_e (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_e), .uart_rx_en(rx_en),
    .uart_rx_ready(ready), .uart_rx_valid(valid_e), .uart_rx_data(data_e),
    .uart_rx_parity_err(pe_e), .uart_rx_frame_err(fe_e),
    .uart_rx_break(brk_e), .uart_rx_overrun(ov_e)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Word = {break, frame_err, parity_err, data}.
  function automatic logic [10:0] model_n(input logic [7:0] d, input logic stop);
    logic fe;
    fe = ~stop;
    return {fe && (d == 8'h00), fe, 1'b0, d};
  endfunction

  function automatic logic [10:0] model_e(input logic [7:0] d, input logic pbit, input logic stop1);
    logic fe;
    int ones;
    fe = ~stop1;
    ones = $countones(d) + int'(pbit);
    return {fe && (d == 8'h00), fe, logic'(ones % 2 == 1), d};
  endfunction

  task automatic line_bit(input int idx, input logic v);
    #1;
    if (idx == 0) rxd_n = v;
    else          rxd_e = v;
    repeat (BIT_CYC) @(posedge clk);
  endtask

  task automatic send_n(input logic [7:0] d, input logic stop, input bit exp_w);
    if (exp_w) exp_n.push_back(model_n(d, stop));
    line_bit(0, 1'b0);
    for (int i = 0; i < 8; i++) line_bit(0, d[i]);
    line_bit(0, stop);
    if (!stop) line_bit(0, 1'b1);
  endtask

  task automatic send_e(input logic [7:0] d, input logic pbit, input logic stop1, input bit exp_w);
    if (exp_w) exp_e.push_back(model_e(d, pbit, stop1));
    line_bit(1, 1'b0);
    for (int i = 0; i < 8; i++) line_bit(1, d[i]);
    line_bit(1, pbit);
    line_bit(1, stop1);
    line_bit(1, 1'b1);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_n.size() != 0 || exp_e.size() != 0) && k < 4000) begin
      @(posedge clk);
      k++;
    end
    check("drain_pending_words", exp_n.size() + exp_e.size(), 0);
  endtask

  // Compare process: outputs sampled mid-cycle; ready is stable until the next edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (ov_n) ov_cnt_n++;
      if (ov_e) ov_cnt_e++;
      if (valid_n) vcnt_n++;
      if (exp_n.size() == 0) begin
        check("n_valid_without_word", 32'(valid_n), 0);
      end else if (valid_n) begin
        check("n_word", 32'({brk_n, fe_n, pe_n, data_n}), 32'(exp_n[0]));
        if (ready) begin
          last_n = {brk_n, fe_n, pe_n, data_n};
          void'(exp_n.pop_front());
        end
      end
      if (exp_e.size() == 0) begin
        check("e_valid_without_word", 32'(valid_e), 0);
      end else if (valid_e) begin
        check("e_word", 32'({brk_e, fe_e, pe_e, data_e}), 32'(exp_e[0]));
        if (ready) begin
          last_e = {brk_e, fe_e, pe_e, data_e};
          void'(exp_e.pop_front());
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int ov0;
    logic [7:0] d;
    logic [7:0] dn;
    logic [7:0] de;
    logic pb, sn, se;

    repeat (5) @(posedge clk);
    #1;
    check("reset_outputs_n", 32'({ov_n, brk_n, fe_n, pe_n, valid_n, data_n}), 0);
    check("reset_outputs_e", 32'({ov_e, brk_e, fe_e, pe_e, valid_e, data_e}), 0);
    resetn = 1'b1;
    repeat (20) @(posedge clk);

    // 8N1 0xA5 and 8E2 0x03 with parity bit 1 (three ones: parity error).
    v0 = vcnt_n;
    fork
      send_n(8'hA5, 1'b1, 1'b1);
      send_e(8'h03, 1'b1, 1'b1, 1'b1);
    join
    wait_drain();
    check("a5_valid_cycles", vcnt_n - v0, 1);
    check("a5_word", 32'(last_n), 32'h0A5);
    check("e03_word", 32'(last_e), 32'h103);

    // Short low glitch must not produce a word; the next frame must be clean.
    #1 rxd_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rxd_n = 1'b1;
    repeat (2 * BIT_CYC) @(posedge clk);
    send_n(8'h5A, 1'b1, 1'b1);
    wait_drain();
    check("5a_word", 32'(last_n), 32'h05A);

    // Line held low for 12 bit times: exactly one break word.
    exp_n.push_back(model_n(8'h00, 1'b0));
    #1 rxd_n = 1'b0;
    repeat (12 * BIT_CYC) @(posedge clk);
    #1 rxd_n = 1'b1;
    repeat (BIT_CYC) @(posedge clk);
    wait_drain();
    check("break_word", 32'(last_n), 32'h600);

    // Overrun: consumer stalled, DEPTH+1 frames; the last is dropped.
    #1 ready = 1'b0;
    ov0 = ov_cnt_n;
    for (int i = 0; i <= DEPTH; i++) begin
      d = 8'(8'h11 * (i + 1));
      send_n(d, 1'b1, i < DEPTH);
      repeat (20) @(posedge clk);
    end
    #1;
    check("overrun_pulse_cycles", ov_cnt_n - ov0, 1);
    check("overrun_head_data", 32'(data_n), 32'h11);
    check("overrun_head_valid", 32'(valid_n), 1);
    @(posedge clk);
    #1 ready = 1'b1;
    wait_drain();
    d = 8'(8'h11 * DEPTH);
    check("overrun_last_popped", 32'(last_n), 32'(d));

    // Enable dropped mid-frame: nothing committed.
    v0 = vcnt_n;
    line_bit(0, 1'b0);
    line_bit(0, 1'b1);
    fork
      line_bit(0, 1'b0);
      begin
        repeat (200) @(posedge clk);
        #1 rx_en = 1'b0;
      end
    join
    for (int i = 0; i < 5; i++) line_bit(0, logic'(i % 2));
    line_bit(0, 1'b1);
    #1 rx_en = 1'b1;
    repeat (2 * BIT_CYC) @(posedge clk);
    check("abort_no_word", vcnt_n - v0, 0);

    // Asynchronous reset mid-DATA with a word buffered, then a clean frame.
    #1 ready = 1'b0;
    send_n(8'h3C, 1'b1, 1'b1);
    repeat (50) @(posedge clk);
    #1;
    check("pre_reset_valid", 32'(valid_n), 1);
    d = 8'h77;
    line_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) line_bit(0, d[i]);
    repeat (200) @(posedge clk);
    #1 resetn = 1'b0;
    exp_n.delete();
    exp_e.delete();
    #1;
    check("reset_mid_frame_n", 32'({ov_n, brk_n, fe_n, pe_n, valid_n, data_n}), 0);
    rxd_n = 1'b1;
    ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (20) @(posedge clk);
    send_n(8'hC3, 1'b1, 1'b1);
    wait_drain();
    check("c3_word", 32'(last_n), 32'h0C3);

    // Random frames on both lines with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int it = 0; it < 6; it++) begin
      dn = 8'($urandom);
      de = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      sn = ($urandom_range(0, 5) != 0);
      se = ($urandom_range(0, 5) != 0);
      fork
        send_n(dn, sn, 1'b1);
        send_e(de, pb, se, 1'b1);
      join
      repeat ($urandom_range(2, 40)) @(posedge clk);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1 ready = 1'b1;
    wait_drain();

    check("total_overruns_n", ov_cnt_n, 1);
    check("total_overruns_e", ov_cnt_e, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
